// File: rtl/fib_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : fib_result_collector
// Description : Times the Fibonacci generator from reset release, then captures
//               its result (or a timeout) once and presents it on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_result_collector #(
    parameter int unsigned EXPECTED       = 144,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fib_done,
    input  logic [31:0]      fib_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [CNT_W-1:0] out_cycles,
    output logic             pass,
    output logic             fail,
    output logic             timeout
);

    localparam logic [31:0]      C_EXPECTED = 32'(EXPECTED);
    localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_COUNT    = 2'd0,
        ST_PRESENT  = 2'd1,
        ST_FINISHED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      result_q, result_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic             w_match;

    assign w_match = (fib_result == C_EXPECTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_COUNT;
            cnt_q     <= '0;
            result_q  <= '0;
            cycles_q  <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            cycles_q  <= cycles_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        cycles_d  = cycles_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_COUNT: begin
                // done takes priority over a coincident timeout
                if (fib_done) begin
                    result_d = fib_result;
                    cycles_d = cnt_q;
                    pass_d   = w_match;
                    fail_d   = !w_match;
                    state_d  = ST_PRESENT;
                end else if (cnt_q == C_TIMEOUT) begin
                    result_d  = '0;
                    cycles_d  = C_TIMEOUT;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = ST_PRESENT;
                end else if (cnt_q != C_CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    state_d = ST_FINISHED;
                end
            end
            ST_FINISHED: begin
                state_d = ST_FINISHED;
            end
            default: begin
                state_d = ST_COUNT;
            end
        endcase
    end

    assign out_valid  = (state_q == ST_PRESENT);
    assign out_result = result_q;
    assign out_cycles = cycles_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_result_collector
// Description : Directed and randomized trials of fib_result_collector against
//               an edge-indexed reference model of the capture/handshake rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_result_collector;

    localparam int unsigned C_EXPECTED = 144;
    localparam int unsigned C_TIMEOUT  = 20;
    localparam int unsigned C_CNT_W    = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fib_done = 1'b0;
    logic [31:0]        fib_result = '0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic [31:0]        out_result;
    logic [C_CNT_W-1:0] out_cycles;
    logic               pass;
    logic               fail;
    logic               timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    fib_result_collector #(
        .EXPECTED       (C_EXPECTED),
        .TIMEOUT_CYCLES (C_TIMEOUT),
        .CNT_W          (C_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fib_done   (fib_done),
        .fib_result (fib_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cycles (out_cycles),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit v, input logic [31:0] r,
                             input int c, input bit p, input bit f, input bit t);
        check({tag, ".valid"},   32'(out_valid),  32'(v));
        check({tag, ".result"},  out_result,      r);
        check({tag, ".cycles"},  32'(out_cycles), 32'(c));
        check({tag, ".pass"},    32'(pass),       32'(p));
        check({tag, ".fail"},    32'(fail),       32'(f));
        check({tag, ".timeout"}, 32'(timeout),    32'(t));
    endtask

    // d: edges with fib_done low before it rises; hold<0 means random ready,
    // otherwise ready stays low for the first hold edges spent presenting.
    task automatic run_trial(input string name, input int d, input logic [31:0] res,
                             input int hold, input bit abort);
        bit          captured = 0, present = 0, finished = 0, rdy;
        logic [31:0] e_res = '0;
        int          e_cyc = 0, pres_n = 0, post = 0;
        bit          e_p = 0, e_f = 0, e_t = 0;
        rst = 1'b1; fib_done = 1'b0; out_ready = 1'b0; fib_result = '0;
        #3;
        check_all({name, ".reset"}, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int k = 1; k <= int'(C_TIMEOUT) + 60; k++) begin
            fib_done   = (k > d);
            fib_result = (k > d && !finished && !present) ? res : $urandom;
            rdy        = (hold < 0) ? 1'($urandom_range(0, 1)) : (pres_n >= hold);
            out_ready  = rdy;
            @(posedge clk); #1;
            if (present) begin
                pres_n++;
                if (rdy) begin
                    present  = 0;
                    finished = 1;
                end
            end else if (!captured) begin
                if (k > d) begin
                    captured = 1; present = 1;
                    e_res = res; e_cyc = k - 1;
                    e_p = (res == C_EXPECTED); e_f = !e_p;
                end else if (k - 1 == int'(C_TIMEOUT)) begin
                    captured = 1; present = 1;
                    e_res = '0; e_cyc = int'(C_TIMEOUT);
                    e_t = 1; e_f = 1; e_p = 0;
                end
            end
            check_all(name, present, e_res, e_cyc, e_p, e_f, e_t);
            if (abort && present) begin
                rst = 1'b1;
                #2;
                check_all({name, ".abort"}, 0, 0, 0, 0, 0, 0);
                return;
            end
            if (finished) begin
                post++;
                if (post > 3) break;
            end
        end
        check({name, ".record_done"}, 32'(finished), 32'd1);
    endtask

    initial begin
        run_trial("match",        11, 32'd144, 0,  0);
        run_trial("mismatch",     11, 32'd89,  0,  0);
        run_trial("timeout",      30, 32'd144, 0,  0);
        run_trial("done_at_rst",   0, 32'd144, 0,  0);
        run_trial("done_at_to",   20, 32'd144, 0,  0);
        run_trial("to_boundary",  21, 32'd144, 0,  0);
        run_trial("backpressure", 11, 32'd144, 5,  0);
        run_trial("abort",        11, 32'd144, 50, 1);
        run_trial("after_abort",  11, 32'd144, 0,  0);
        run_trial("high_bit",      3, 32'h8000_0090, 1, 0);
        for (int i = 0; i < 12; i++) begin
            int          d;
            logic [31:0] r;
            d = int'($urandom_range(0, 26));
            r = ($urandom_range(0, 1) == 1) ? 32'd144 : 32'($urandom);
            run_trial($sformatf("rand%0d", i), d, r, -1, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
